// File: rtl/mem_readback_serializer.sv
// Memory read-back serializer: executes a decoded read command on the activation,
// parameter or instruction memory and streams an echoed header plus data bytes MSB-first.
module mem_readback_serializer #(
   parameter int unsigned WIDTH_SPI_WORD   = 8,
   parameter int unsigned WIDTH_ADDR_ACT   = 11,
   parameter int unsigned WIDTH_ACT_MEM    = 8,
   parameter int unsigned WIDTH_ADDR_PARAM = 13,
   parameter int unsigned WIDTH_PARAM_MEM  = 128,
   parameter int unsigned WIDTH_ADDR_INST  = 6,
   parameter int unsigned WIDTH_INST_MEM   = 80,
   parameter logic [1:0]  ACT_MEM_HEADER   = 2'b10,
   parameter logic [1:0]  PARAM_MEM_HEADER = 2'b01,
   parameter logic [1:0]  INST_MEM_HEADER  = 2'b11,
   parameter int unsigned MEM_RD_LATENCY   = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [WIDTH_SPI_WORD-1:0]   cmd_header,
   input  logic [12:0]                 cmd_addr,
   input  logic [11:0]                 cmd_burst_length,
   input  logic                        abort,
   output logic [WIDTH_ADDR_ACT-1:0]   act_mem_addr,
   output logic                        act_mem_rden,
   input  logic [WIDTH_ACT_MEM-1:0]    act_mem_q,
   output logic [WIDTH_ADDR_PARAM-1:0] param_mem_addr,
   output logic                        param_mem_rden,
   input  logic [WIDTH_PARAM_MEM-1:0]  param_mem_q,
   output logic [WIDTH_ADDR_INST-1:0]  inst_mem_addr,
   output logic                        inst_mem_rden,
   input  logic [WIDTH_INST_MEM-1:0]   inst_mem_q,
   input  logic                        write_fifo_full,
   output logic                        wr_req,
   output logic [WIDTH_SPI_WORD-1:0]   wr_data,
   output logic                        busy,
   output logic                        done,
   output logic                        cmd_err
);

   localparam int unsigned W           = WIDTH_SPI_WORD;
   localparam int unsigned ACT_BYTES   = (WIDTH_ACT_MEM + W - 1) / W;
   localparam int unsigned PARAM_BYTES = (WIDTH_PARAM_MEM + W - 1) / W;
   localparam int unsigned INST_BYTES  = (WIDTH_INST_MEM + W - 1) / W;
   localparam int unsigned MAX_AP      = (ACT_BYTES > PARAM_BYTES) ? ACT_BYTES : PARAM_BYTES;
   localparam int unsigned MAX_BYTES   = (MAX_AP > INST_BYTES) ? MAX_AP : INST_BYTES;
   localparam int unsigned SR_W        = MAX_BYTES * W;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_ISSUE, S_WAIT, S_LOAD, S_SHIFT, S_NEXT, S_DONE
   } state_e;

   typedef enum logic [1:0] {M_ACT, M_PARAM, M_INST} mem_e;

   state_e                      state_q;
   mem_e                        mem_q;
   logic [W-1:0]                hdr_q;
   logic [12:0]                 addr_q;
   logic [11:0]                 len_q;
   logic [11:0]                 word_q;
   logic [SR_W-1:0]             sr_q;
   logic [7:0]                  bcnt_q;
   logic [7:0]                  wait_q;
   logic                        act_rden_q, param_rden_q, inst_rden_q;
   logic                        busy_q, done_q, cmd_err_q;

   logic                        cmd_ok_d;
   mem_e                        cmd_mem_d;
   logic [12:0]                 cmd_addr_d;
   logic [11:0]                 cmd_len_d;
   logic [WIDTH_ADDR_ACT-1:0]   act_inc_d;
   logic [WIDTH_ADDR_PARAM-1:0] param_inc_d;
   logic [WIDTH_ADDR_INST-1:0]  inst_inc_d;
   logic [12:0]                 addr_nxt_d;
   logic [11:0]                 word_inc_d;

   always_comb begin
      cmd_ok_d   = 1'b0;
      cmd_mem_d  = M_ACT;
      cmd_addr_d = '0;
      if (cmd_header[7:6] == ACT_MEM_HEADER) begin
         cmd_ok_d   = 1'b1;
         cmd_mem_d  = M_ACT;
         cmd_addr_d = 13'(cmd_addr[WIDTH_ADDR_ACT-1:0]);
      end else if (cmd_header[7:6] == PARAM_MEM_HEADER) begin
         cmd_ok_d   = 1'b1;
         cmd_mem_d  = M_PARAM;
         cmd_addr_d = 13'(cmd_addr[WIDTH_ADDR_PARAM-1:0]);
      end else if (cmd_header[7:6] == INST_MEM_HEADER) begin
         cmd_ok_d   = 1'b1;
         cmd_mem_d  = M_INST;
         cmd_addr_d = 13'(cmd_addr[WIDTH_ADDR_INST-1:0]);
      end
      if (cmd_header[7:6] == 2'b00 || cmd_header[5] || cmd_header[3:2] != 2'b11)
         cmd_ok_d = 1'b0;
      cmd_len_d = (cmd_header[4] && cmd_burst_length != '0) ? cmd_burst_length : 12'd1;

      // Address increments wrap within the selected memory's own address width.
      act_inc_d   = addr_q[WIDTH_ADDR_ACT-1:0] + 1'b1;
      param_inc_d = addr_q[WIDTH_ADDR_PARAM-1:0] + 1'b1;
      inst_inc_d  = addr_q[WIDTH_ADDR_INST-1:0] + 1'b1;
      case (mem_q)
         M_PARAM: addr_nxt_d = 13'(param_inc_d);
         M_INST:  addr_nxt_d = 13'(inst_inc_d);
         default: addr_nxt_d = 13'(act_inc_d);
      endcase
      word_inc_d = word_q + 12'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         mem_q        <= M_ACT;
         hdr_q        <= '0;
         addr_q       <= '0;
         len_q        <= '0;
         word_q       <= '0;
         sr_q         <= '0;
         bcnt_q       <= '0;
         wait_q       <= '0;
         act_rden_q   <= 1'b0;
         param_rden_q <= 1'b0;
         inst_rden_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else if (abort) begin
         state_q      <= S_IDLE;
         act_rden_q   <= 1'b0;
         param_rden_q <= 1'b0;
         inst_rden_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         done_q       <= 1'b0;
         cmd_err_q    <= 1'b0;
         act_rden_q   <= 1'b0;
         param_rden_q <= 1'b0;
         inst_rden_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (cmd_ok_d) begin
                     hdr_q   <= cmd_header;
                     mem_q   <= cmd_mem_d;
                     addr_q  <= cmd_addr_d;
                     len_q   <= cmd_len_d;
                     word_q  <= '0;
                     busy_q  <= 1'b1;
                     state_q <= S_HDR;
                  end else begin
                     cmd_err_q <= 1'b1;
                  end
               end
            end
            S_HDR: begin
               if (!write_fifo_full) begin
                  act_rden_q   <= (mem_q == M_ACT);
                  param_rden_q <= (mem_q == M_PARAM);
                  inst_rden_q  <= (mem_q == M_INST);
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (MEM_RD_LATENCY > 1) begin
                  wait_q  <= 8'(MEM_RD_LATENCY - 2);
                  state_q <= S_WAIT;
               end else begin
                  state_q <= S_LOAD;
               end
            end
            S_WAIT: begin
               if (wait_q == '0) state_q <= S_LOAD;
               else              wait_q  <= wait_q - 8'd1;
            end
            S_LOAD: begin
               // Left-align the word so the first byte out is always sr_q's top byte.
               case (mem_q)
                  M_PARAM: begin
                     sr_q   <= SR_W'(param_mem_q) << (SR_W - WIDTH_PARAM_MEM);
                     bcnt_q <= 8'(PARAM_BYTES);
                  end
                  M_INST: begin
                     sr_q   <= SR_W'(inst_mem_q) << (SR_W - WIDTH_INST_MEM);
                     bcnt_q <= 8'(INST_BYTES);
                  end
                  default: begin
                     sr_q   <= SR_W'(act_mem_q) << (SR_W - WIDTH_ACT_MEM);
                     bcnt_q <= 8'(ACT_BYTES);
                  end
               endcase
               state_q <= S_SHIFT;
            end
            S_SHIFT: begin
               if (!write_fifo_full) begin
                  sr_q   <= sr_q << W;
                  bcnt_q <= bcnt_q - 8'd1;
                  if (bcnt_q == 8'd1) state_q <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (word_inc_d == len_q) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  word_q       <= word_inc_d;
                  addr_q       <= addr_nxt_d;
                  act_rden_q   <= (mem_q == M_ACT);
                  param_rden_q <= (mem_q == M_PARAM);
                  inst_rden_q  <= (mem_q == M_INST);
                  state_q      <= S_ISSUE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_data = '0;
      if (state_q == S_HDR)        wr_data = hdr_q;
      else if (state_q == S_SHIFT) wr_data = sr_q[SR_W-1 -: W];
   end

   assign wr_req         = (state_q == S_HDR || state_q == S_SHIFT) && !write_fifo_full && !abort;
   assign act_mem_addr   = addr_q[WIDTH_ADDR_ACT-1:0];
   assign param_mem_addr = addr_q[WIDTH_ADDR_PARAM-1:0];
   assign inst_mem_addr  = addr_q[WIDTH_ADDR_INST-1:0];
   assign act_mem_rden   = act_rden_q;
   assign param_mem_rden = param_rden_q;
   assign inst_mem_rden  = inst_rden_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign cmd_err        = cmd_err_q;

endmodule

// File: tb/tb_mem_readback_serializer.sv
// Directed bench for mem_readback_serializer: behavioural memories, a TX-FIFO push log,
// and hand-computed byte sequences for each command scenario.
module tb_mem_readback_serializer;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [7:0]    cmd_header = '0;
   logic [12:0]   cmd_addr = '0;
   logic [11:0]   cmd_burst_length = '0;
   logic [10:0]   act_mem_addr;
   logic          act_mem_rden;
   logic [7:0]    act_mem_q = '0;
   logic [12:0]   param_mem_addr;
   logic          param_mem_rden;
   logic [127:0]  param_mem_q = '0;
   logic [5:0]    inst_mem_addr;
   logic          inst_mem_rden;
   logic [79:0]   inst_mem_q = '0;
   logic          write_fifo_full = 1'b0;
   logic          wr_req;
   logic [7:0]    wr_data;
   logic          busy, done, cmd_err;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_readback_serializer #(.MEM_RD_LATENCY(1)) dut (
      .clk(clk), .reset(reset), .start(start), .cmd_header(cmd_header),
      .cmd_addr(cmd_addr), .cmd_burst_length(cmd_burst_length), .abort(abort),
      .act_mem_addr(act_mem_addr), .act_mem_rden(act_mem_rden), .act_mem_q(act_mem_q),
      .param_mem_addr(param_mem_addr), .param_mem_rden(param_mem_rden), .param_mem_q(param_mem_q),
      .inst_mem_addr(inst_mem_addr), .inst_mem_rden(inst_mem_rden), .inst_mem_q(inst_mem_q),
      .write_fifo_full(write_fifo_full), .wr_req(wr_req), .wr_data(wr_data),
      .busy(busy), .done(done), .cmd_err(cmd_err)
   );

   // Memory contents: byte k (k=0 is the MSB byte) of a wide word at address a is {a[3:0], k}.
   function automatic logic [7:0] act_val(input logic [10:0] a);
      return (a == 11'd5) ? 8'hA7 : (a[7:0] ^ 8'h3C);
   endfunction

   function automatic logic [79:0] inst_val(input logic [5:0] a);
      logic [79:0] v;
      for (int k = 0; k < 10; k++) v[79-8*k -: 8] = {a[3:0], 4'(k)};
      return v;
   endfunction

   function automatic logic [127:0] param_val(input logic [12:0] a);
      logic [127:0] v;
      for (int k = 0; k < 16; k++) v[127-8*k -: 8] = {a[3:0], 4'(k)};
      return v;
   endfunction

   always @(posedge clk) begin
      if (act_mem_rden)   act_mem_q   <= act_val(act_mem_addr);
      if (param_mem_rden) param_mem_q <= param_val(param_mem_addr);
      if (inst_mem_rden)  inst_mem_q  <= inst_val(inst_mem_addr);
   end

   logic        bp_en = 1'b0;
   int unsigned bp_phase = 0;
   always begin
      @(posedge clk);
      #1;
      bp_phase++;
      write_fifo_full = bp_en && bp_phase[1];
   end

   logic [7:0]  wlog[$];
   logic [12:0] alog[$], plog[$], ilog[$];
   int act_rd = 0, param_rd = 0, inst_rd = 0, multi_rd = 0, full_viol = 0;
   int done_cnt = 0, done_at = 0, err_cnt = 0, busy_cnt = 0;

   always @(negedge clk) begin
      if (wr_req) begin
         wlog.push_back(wr_data);
         if (write_fifo_full) full_viol++;
      end
      if (act_mem_rden)   begin act_rd++;   alog.push_back(13'(act_mem_addr));   end
      if (param_mem_rden) begin param_rd++; plog.push_back(param_mem_addr);      end
      if (inst_mem_rden)  begin inst_rd++;  ilog.push_back(13'(inst_mem_addr));  end
      if (int'(act_mem_rden) + int'(param_mem_rden) + int'(inst_mem_rden) > 1) multi_rd++;
      if (done) begin done_cnt++; done_at = wlog.size(); end
      if (cmd_err) err_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_byte(input string tag, input int idx, input logic [7:0] exp);
      if (idx < wlog.size()) check(tag, 32'(wlog[idx]), 32'(exp));
      else check({tag, "_present"}, wlog.size(), idx + 1);
   endtask

   task automatic issue(input logic [7:0] h, input logic [12:0] a, input logic [11:0] l);
      @(posedge clk); #1;
      cmd_header = h; cmd_addr = a; cmd_burst_length = l; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base);
      int n = 0;
      while (done_cnt == base && n < 3000) begin @(negedge clk); n++; end
      check($sformatf("%s_done_seen", tag), done_cnt - base, 1);
      repeat (5) @(negedge clk);
   endtask

   task automatic run_act_single(input string tag);
      int wb, ab, db, rb;
      wb = wlog.size(); ab = alog.size(); db = done_cnt; rb = act_rd;
      issue(8'h8C, 13'h0005, 12'd7);   // burst bit clear: length field ignored
      wait_done(tag, db);
      check($sformatf("%s_nbytes", tag), wlog.size() - wb, 2);
      check_byte($sformatf("%s_hdr", tag), wb, 8'h8C);
      check_byte($sformatf("%s_data", tag), wb + 1, 8'hA7);
      check($sformatf("%s_done_once", tag), done_cnt - db, 1);
      check($sformatf("%s_rden_cycles", tag), act_rd - rb, 1);
      if (alog.size() > ab) check($sformatf("%s_rd_addr", tag), 32'(alog[ab]), 32'h5);
      else check($sformatf("%s_rd_addr_present", tag), alog.size(), ab + 1);
      check($sformatf("%s_busy_end", tag), busy, 0);
   endtask

   initial begin : main
      int wb, db, eb, bb, rb, n;
      logic [7:0]  rej[3];
      logic [5:0]  iw[3];
      rej = '{8'h0C, 8'h80, 8'hAC};
      iw  = '{6'h3E, 6'h3F, 6'h00};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_wr_req", wr_req, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_rden", {act_mem_rden, param_mem_rden, inst_mem_rden}, 0);
      check("rst_addr", {act_mem_addr, param_mem_addr, inst_mem_addr}, 0);
      check("rst_pulses", {done, cmd_err}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_act_single("act1");

      // Instruction burst wrapping at the top of the 6-bit address space.
      wb = wlog.size(); rb = ilog.size(); db = done_cnt;
      issue(8'hDC, 13'h003E, 12'd3);
      wait_done("inst", db);
      check("inst_nbytes", wlog.size() - wb, 31);
      check_byte("inst_hdr", wb, 8'hDC);
      for (int w = 0; w < 3; w++)
         for (int k = 0; k < 10; k++)
            check_byte($sformatf("inst_w%0d_b%0d", w, k), wb + 1 + w*10 + k, {iw[w][3:0], 4'(k)});
      check("inst_rd_cnt", ilog.size() - rb, 3);
      for (int w = 0; w < 3; w++)
         if (ilog.size() > rb + w) check($sformatf("inst_rd_addr%0d", w), 32'(ilog[rb+w]), 32'(iw[w]));
      check("inst_multi_rden", multi_rd, 0);

      // Parameter read under back-pressure.
      wb = wlog.size(); rb = plog.size(); db = done_cnt; n = full_viol;
      bp_en = 1'b1;
      issue(8'h4C, 13'h0A5B, 12'd0);
      wait_done("param_bp", db);
      bp_en = 1'b0;
      check("param_bp_nbytes", wlog.size() - wb, 17);
      check_byte("param_bp_hdr", wb, 8'h4C);
      for (int k = 0; k < 16; k++)
         check_byte($sformatf("param_bp_b%0d", k), wb + 1 + k, {4'hB, 4'(k)});
      check("param_bp_push_when_full", full_viol - n, 0);
      check("param_bp_done_after_last", done_at - wb, 17);
      check("param_bp_rd_cnt", plog.size() - rb, 1);
      if (plog.size() > rb) check("param_bp_rd_addr", 32'(plog[rb]), 32'h0A5B);

      // Rejected headers.
      for (int i = 0; i < 3; i++) begin
         wb = wlog.size(); eb = err_cnt; bb = busy_cnt; rb = act_rd + param_rd + inst_rd;
         issue(rej[i], 13'h0001, 12'd1);
         repeat (6) @(negedge clk);
         check($sformatf("rej%0d_cmd_err", i), err_cnt - eb, 1);
         check($sformatf("rej%0d_no_push", i), wlog.size() - wb, 0);
         check($sformatf("rej%0d_no_busy", i), busy_cnt - bb, 0);
         check($sformatf("rej%0d_no_rden", i), act_rd + param_rd + inst_rd - rb, 0);
      end

      // Start and abort together in IDLE: the command must not be taken.
      wb = wlog.size(); bb = busy_cnt; eb = err_cnt;
      @(posedge clk); #1;
      cmd_header = 8'h8C; cmd_addr = 13'h0005; start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      repeat (10) @(negedge clk);
      check("start_abort_no_busy", busy_cnt - bb, 0);
      check("start_abort_no_push", wlog.size() - wb, 0);
      check("start_abort_no_err", err_cnt - eb, 0);

      // Abort a parameter burst after five data bytes.
      wb = wlog.size(); db = done_cnt; rb = plog.size();
      issue(8'h5C, 13'h0010, 12'd4);
      n = 0;
      while (wlog.size() - wb < 6 && n < 500) begin @(posedge clk); n++; end
      check("abort_reach_5_bytes", wlog.size() - wb, 6);
      #1; abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_wr_req", wr_req, 0);
      check("abort_rden", {act_mem_rden, param_mem_rden, inst_mem_rden}, 0);
      repeat (20) @(negedge clk);
      check("abort_no_more_push", wlog.size() - wb, 6);
      check("abort_no_done", done_cnt - db, 0);
      check_byte("abort_hdr", wb, 8'h5C);
      for (int k = 0; k < 5; k++)
         check_byte($sformatf("abort_b%0d", k), wb + 1 + k, {4'h0, 4'(k)});
      check("abort_rd_cnt", plog.size() - rb, 1);
      run_act_single("post_abort");

      // Reset while shifting out a parameter word.
      wb = wlog.size(); db = done_cnt;
      issue(8'h4C, 13'h0003, 12'd0);
      n = 0;
      while (wlog.size() - wb < 4 && n < 500) begin @(posedge clk); n++; end
      check("rst_mid_reach_shift", wlog.size() - wb, 4);
      #1; reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_wr_req", wr_req, 0);
      check("rst_mid_wr_data", wr_data, 0);
      check("rst_mid_rden", {act_mem_rden, param_mem_rden, inst_mem_rden}, 0);
      check("rst_mid_addr", {act_mem_addr, param_mem_addr, inst_mem_addr}, 0);
      check("rst_mid_pulses", {done, cmd_err}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid_no_done", done_cnt - db, 0);
      run_act_single("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mem_readback_serializer.md
Name: mem_readback_serializer

Overview:
- Return-path counterpart of the SPI command packetizer: executes a decoded memory read-back command and streams the result out as 8-bit SPI words into the outbound (SPI TX) write FIFO.
- Reads activation, parameter or instruction memory (single word or burst), then splits each wide word into bytes MSB-first behind an echoed header byte.
- Sits between the command decoder and the SPI transmit FIFO, with a read port onto each of the three memories.

Parameters:
- WIDTH_SPI_WORD, 8, output byte width.
- WIDTH_ADDR_ACT, 11, activation memory address width.
- WIDTH_ACT_MEM, 8, activation memory data width.
- WIDTH_ADDR_PARAM, 13, parameter memory address width.
- WIDTH_PARAM_MEM, 128, parameter memory data width.
- WIDTH_ADDR_INST, 6, instruction memory address width.
- WIDTH_INST_MEM, 80, instruction memory data width.
- ACT_MEM_HEADER / PARAM_MEM_HEADER / INST_MEM_HEADER, 2'b10 / 2'b01 / 2'b11, header[7:6] memory select codes.
- MEM_RD_LATENCY, 1, clock cycles from rden to valid q (minimum 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; accepted only while busy=0.
- cmd_header  in  8  command header: [7:6] memory select, [5] op (0 = read-back), [4] burst, [3:2] valid (must be 2'b11).
- cmd_addr  in  13  start address; low bits used per memory.
- cmd_burst_length  in  12  word count for burst commands.
- abort  in  1  synchronous cancel, e.g. chip select released.
- act_mem_addr  out  WIDTH_ADDR_ACT  activation read address.
- act_mem_rden  out  1  activation read enable.
- act_mem_q  in  WIDTH_ACT_MEM  activation read data.
- param_mem_addr / param_mem_rden / param_mem_q  out / out / in  13 / 1 / 128  parameter memory read port.
- inst_mem_addr / inst_mem_rden / inst_mem_q  out / out / in  6 / 1 / 80  instruction memory read port.
- write_fifo_full  in  1  TX FIFO full.
- wr_req  out  1  TX FIFO push.
- wr_data  out  8  TX FIFO data.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse on normal completion.
- cmd_err  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset: all outputs 0, all addresses 0, state IDLE. Reset mid-command drops the command with no done pulse.
- States: IDLE, HDR, ISSUE, WAIT, LOAD, SHIFT, NEXT, DONE.
- IDLE:
  - On start, reject the command if header[3:2]!=2'b11, header[7:6]==2'b00, or header[5]==1. Rejection: cmd_err=1 for one cycle, stay IDLE, no FIFO push.
  - Otherwise latch header, address and length, set busy=1, go to HDR.
  - Length = cmd_burst_length if header[4]=1, else 1. A burst length of 0 is treated as 1.
- HDR: wr_req = !write_fifo_full, wr_data = latched header. On a push, go to ISSUE.
- ISSUE: the selected memory's rden=1 for exactly one cycle at the current address; non-selected rden stay 0. Go to WAIT.
- WAIT: wait MEM_RD_LATENCY-1 further cycles, then go to LOAD.
- LOAD:
  - Capture q into the shift register, left-aligned with zero padding to a whole number of bytes.
  - Byte count = ceil(width/8): act 1, inst 10, param 16.
  - Go to SHIFT.
- SHIFT:
  - wr_req = !write_fifo_full (combinational); wr_data = top byte of the shift register.
  - On each push: shift left 8, decrement byte count.
  - After the last byte, go to NEXT.
  - While write_fifo_full=1: no push, contents held, no bytes lost or duplicated.
- NEXT:
  - Increment word count. If it equals length, go to DONE.
  - Otherwise increment the address (modulo 2^address width; wraps to 0) and go to ISSUE.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- Throughput with FIFO never full: one byte per cycle in SHIFT, plus 3+MEM_RD_LATENCY-1 cycles of overhead per word.
- Output sequence per command: header byte, then length × bytes_per_word data bytes, MSB first.
- abort: overrides all other activity. Next cycle: state IDLE, busy=0, rden=0, wr_req=0, no done pulse.
- start while busy=1: ignored.
- Simultaneous start and abort in IDLE: abort wins and the command is not accepted.

Test Plan:
- Single act read: header 8'b1000_1100, addr 11'h005, act_mem_q=8'hA7 → FIFO receives 8'h8C then 8'hA7; done pulses once; act_mem_rden high for exactly 1 cycle at addr 5.
- Inst burst: header 8'b1101_1100, addr 6'h3E, length 3 → addresses 3E, 3F, 00 (wrap); FIFO receives 1 + 30 bytes; each word's bytes MSB first.
- Param read with back-pressure: write_fifo_full toggled 1/0 every 2 cycles → all 17 bytes delivered in order, none duplicated; done only after the 17th push.
- Rejected command: header 8'b0000_1100 or 8'b1000_0000 → cmd_err pulse, wr_req never asserted, busy stays 0.
- Abort mid-burst after 5 data bytes of a param burst of 4 → busy=0 next cycle, no further pushes, no done pulse; a new start is then accepted.
- Reset asserted during SHIFT → all outputs 0 next cycle; a following single act read behaves as in scenario 1.
